resq_request_queue: RTL and testbench

Four-entry priority buffer placed directly upstream of the ResQ allocation datapath. It accepts incoming emergency requests (zone, priority, quantity) over a valid/ready handshake, stores them in slot registers, and offers one request at a time to the allocator: highest priority first, lowest slot index on ties. Requests are dropped and counted when the buffer is full.

---
 rtl/resq_request_queue.sv | 125 ++++++++++++
 tb/tb_resq_request_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/resq_request_queue.sv
// Four-slot priority buffer ahead of the ResQ allocator: valid/ready in, one offered request out,
// highest priority first with lowest slot index winning ties; overflow requests are counted.
module resq_request_queue (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_zone,
  input  logic [1:0] in_prio,
  input  logic [7:0] in_qty,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_zone,
  output logic [1:0] out_prio,
  output logic [7:0] out_qty,
  output logic [2:0] occupancy,
  output logic       full,
  output logic       empty,
  output logic [7:0] drop_cnt
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StOffer = 1'b1;

  logic [3:0]      occ_q, occ_d;
  logic [3:0][1:0] zone_q;
  logic [3:0][1:0] prio_q;
  logic [3:0][7:0] qty_q;
  logic [0:0]      state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [7:0]      drop_q, drop_d;

  logic [1:0] free_idx;
  logic [1:0] best_idx;
  logic [1:0] best_prio;
  logic       best_found;
  logic       push;
  logic       pop;

  always_comb begin
    occupancy = {2'b00, occ_q[0]} + {2'b00, occ_q[1]} + {2'b00, occ_q[2]} + {2'b00, occ_q[3]};
    full      = (occupancy == 3'd4);
    empty     = (occupancy == 3'd0);
    in_ready  = !full;
  end

  // Lowest free slot; only used when not full.
  always_comb begin
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!occ_q[i]) free_idx = 2'(i);
    end
  end

  // Strict greater-than keeps the lowest index on equal priority.
  always_comb begin
    best_idx   = 2'd0;
    best_prio  = 2'd0;
    best_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (occ_q[i] && (!best_found || (prio_q[i] > best_prio))) begin
        best_found = 1'b1;
        best_idx   = 2'(i);
        best_prio  = prio_q[i];
      end
    end
  end

  assign push = in_valid && in_ready && (in_qty != 8'd0);
  assign pop  = (state_q == StOffer) && out_ready;

  always_comb begin
    occ_d   = occ_q;
    state_d = state_q;
    sel_d   = sel_q;
    drop_d  = drop_q;
    // Free slot is picked from pre-pop occ, so it can never be the popped slot.
    if (pop)  occ_d[sel_q]    = 1'b0;
    if (push) occ_d[free_idx] = 1'b1;
    case (state_q)
      StIdle: begin
        if (|occ_q) begin
          state_d = StOffer;
          sel_d   = best_idx;
        end
      end
      StOffer: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (in_valid && !in_ready && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= '0;
      zone_q  <= '0;
      prio_q  <= '0;
      qty_q   <= '0;
      state_q <= StIdle;
      sel_q   <= '0;
      drop_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
      if (push) begin
        zone_q[free_idx] <= in_zone;
        prio_q[free_idx] <= in_prio;
        qty_q[free_idx]  <= in_qty;
      end
    end
  end

  always_comb begin
    out_valid = (state_q == StOffer);
    out_zone  = out_valid ? zone_q[sel_q] : 2'd0;
    out_prio  = out_valid ? prio_q[sel_q] : 2'd0;
    out_qty   = out_valid ? qty_q[sel_q]  : 8'd0;
    drop_cnt  = drop_q;
  end

endmodule

// File: tb/tb_resq_request_queue.sv
// Directed bench for resq_request_queue; expected offers are queued in the order the
// allocator should see them and compared as each offer appears.
module tb_resq_request_queue;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_zone;
  logic [1:0] in_prio;
  logic [7:0] in_qty;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_zone;
  logic [1:0] out_prio;
  logic [7:0] out_qty;
  logic [2:0] occupancy;
  logic       full;
  logic       empty;
  logic [7:0] drop_cnt;

  typedef struct packed {
    logic [1:0] z;
    logic [1:0] p;
    logic [7:0] q;
  } req_t;

  req_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  resq_request_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_zone   (in_zone),
    .in_prio   (in_prio),
    .in_qty    (in_qty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_zone  (out_zone),
    .out_prio  (out_prio),
    .out_qty   (out_qty),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [1:0] z, input logic [1:0] p, input logic [7:0] q);
    in_valid = 1'b1;
    in_zone  = z;
    in_prio  = p;
    in_qty   = q;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_req(input logic [1:0] z, input logic [1:0] p, input logic [7:0] q);
    req_t r;
    r.z = z;
    r.p = p;
    r.q = q;
    sb.push_back(r);
  endtask

  task automatic check_offer(input string tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_zone"}, {30'd0, out_zone}, {30'd0, sb[0].z});
      chk({tag, "_prio"}, {30'd0, out_prio}, {30'd0, sb[0].p});
      chk({tag, "_qty"},  {24'd0, out_qty},  {24'd0, sb[0].q});
    end
  endtask

  task automatic drain(input string tag);
    int last;
    req_t r;
    last = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (out_valid) begin
        check_offer(tag);
        if (last >= 0) chk({tag, "_pop_spacing"}, cyc - last, 2);
        last = cyc;
        r = sb.pop_front();
      end
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_all_offered"}, sb.size(), 0);
    chk({tag, "_occ_after"}, {29'd0, occupancy}, 0);
    chk({tag, "_valid_after"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    req_t r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_zone   = '0;
    in_prio   = '0;
    in_qty    = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_occupancy", {29'd0, occupancy}, 0);
    chk("rst_drop", {24'd0, drop_cnt}, 0);
    chk("rst_out_qty", {24'd0, out_qty}, 0);
    #2 rst_n = 1'b1;

    // Single push, stalled offer, then take.
    expect_req(2'd2, 2'd1, 8'h10);
    push(2'd2, 2'd1, 8'h10);
    chk("s1_occ_edge1", {29'd0, occupancy}, 1);
    chk("s1_valid_edge1", {31'd0, out_valid}, 0);
    tick();
    chk("s1_valid_edge2", {31'd0, out_valid}, 1);
    check_offer("s1_offer");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s1_stall_valid", {31'd0, out_valid}, 1);
      check_offer("s1_stall");
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    r = sb.pop_front();
    chk("s1_occ_taken", {29'd0, occupancy}, 0);
    chk("s1_valid_taken", {31'd0, out_valid}, 0);
    chk("s1_zone_zeroed", {30'd0, out_zone}, 0);

    // Priority ordering: slots hold z2/p3, z1/p2, z3/p2, z0/p0.
    expect_req(2'd2, 2'd3, 8'h21);
    expect_req(2'd1, 2'd2, 8'h22);
    expect_req(2'd3, 2'd2, 8'h23);
    expect_req(2'd0, 2'd0, 8'h24);
    push(2'd2, 2'd3, 8'h21);
    push(2'd1, 2'd2, 8'h22);
    push(2'd3, 2'd2, 8'h23);
    push(2'd0, 2'd0, 8'h24);
    chk("s2_full", {31'd0, full}, 1);
    drain("s2");

    // Zero-quantity request is accepted and discarded.
    push(2'd1, 2'd3, 8'h00);
    chk("s6_occ", {29'd0, occupancy}, 0);
    tick();
    chk("s6_valid", {31'd0, out_valid}, 0);
    chk("s6_empty", {31'd0, empty}, 1);
    chk("s6_drop", {24'd0, drop_cnt}, 0);

    // Fill, overflow, saturate the drop counter.
    expect_req(2'd0, 2'd1, 8'h11);
    expect_req(2'd1, 2'd1, 8'h22);
    expect_req(2'd2, 2'd1, 8'h33);
    expect_req(2'd3, 2'd1, 8'h44);
    push(2'd0, 2'd1, 8'h11);
    push(2'd1, 2'd1, 8'h22);
    push(2'd2, 2'd1, 8'h33);
    push(2'd3, 2'd1, 8'h44);
    chk("s3_full", {31'd0, full}, 1);
    chk("s3_in_ready", {31'd0, in_ready}, 0);
    check_offer("s3_offer");
    for (int i = 0; i < 3; i++) push(2'd3, 2'd3, 8'h99);
    chk("s3_drop3", {24'd0, drop_cnt}, 3);
    chk("s3_occ4", {29'd0, occupancy}, 4);
    check_offer("s3_offer_kept");
    in_valid = 1'b1;
    repeat (260) tick();
    in_valid = 1'b0;
    chk("s3_drop_sat", {24'd0, drop_cnt}, 255);
    drain("s3");

    // No preemption of a stalled offer.
    expect_req(2'd0, 2'd1, 8'h55);
    expect_req(2'd3, 2'd3, 8'h66);
    push(2'd0, 2'd1, 8'h55);
    tick();
    chk("s4_valid", {31'd0, out_valid}, 1);
    push(2'd3, 2'd3, 8'h66);
    repeat (3) tick();
    check_offer("s4_no_preempt");
    chk("s4_occ", {29'd0, occupancy}, 2);
    drain("s4");

    // Simultaneous push and pop at occupancy 3.
    expect_req(2'd0, 2'd2, 8'h01);
    expect_req(2'd3, 2'd3, 8'h04);
    expect_req(2'd1, 2'd1, 8'h02);
    expect_req(2'd2, 2'd0, 8'h03);
    push(2'd0, 2'd2, 8'h01);
    push(2'd1, 2'd1, 8'h02);
    push(2'd2, 2'd0, 8'h03);
    chk("s5_occ3", {29'd0, occupancy}, 3);
    chk("s5_valid", {31'd0, out_valid}, 1);
    check_offer("s5_first");
    r = sb.pop_front();
    out_ready = 1'b1;
    push(2'd3, 2'd3, 8'h04);
    out_ready = 1'b0;
    chk("s5_occ_still3", {29'd0, occupancy}, 3);
    chk("s5_valid_low", {31'd0, out_valid}, 0);
    drain("s5");

    // Async reset in the middle of an offer.
    push(2'd1, 2'd2, 8'h77);
    tick();
    chk("s7_valid", {31'd0, out_valid}, 1);
    chk("s7_drop_pre", {24'd0, drop_cnt}, 255);
    #3 rst_n = 1'b0;
    #1;
    chk("s7_rst_valid", {31'd0, out_valid}, 0);
    chk("s7_rst_occ", {29'd0, occupancy}, 0);
    chk("s7_rst_drop", {24'd0, drop_cnt}, 0);
    chk("s7_rst_ready", {31'd0, in_ready}, 1);
    chk("s7_rst_empty", {31'd0, empty}, 1);
    #2 rst_n = 1'b1;
    tick();
    expect_req(2'd2, 2'd2, 8'h88);
    push(2'd2, 2'd2, 8'h88);
    chk("s7_valid_n", {31'd0, out_valid}, 0);
    tick();
    chk("s7_valid_n1", {31'd0, out_valid}, 1);
    drain("s7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
